vram_write_scheduler_m: RTL and testbench

VRAM_WRITE_SCHEDULER_M -- requirements
Module: vram_write_scheduler_m

---
 rtl/vram_write_scheduler_m_pkg.sv | 21 ++
 rtl/vram_write_scheduler_m_if.sv | 38 +++
 rtl/vram_write_scheduler_m_sync_fifo.sv | 61 ++++++
 rtl/vram_write_scheduler_m.sv | 115 +++++++++++
 tb/tb_vram_write_scheduler_m.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vram_write_scheduler_m_pkg.sv
// Shared GPU definitions for the VRAM write scheduler: scheduler state
// encoding, the VRAM window base, and default sizing.
package vram_write_scheduler_m_pkg;

  // CPU writes land in the 0x3000-0x3FFF window; ports carry only the offset.
  localparam int unsigned VRAM_BASE          = 32'h3000;
  localparam int          FIFO_DEPTH_DEFAULT = 8;
  localparam int          ADDR_W_DEFAULT     = 12;
  localparam int          DATA_W             = 8;

  typedef enum logic {
    ST_WAIT  = 1'b0,
    ST_DRAIN = 1'b1
  } sched_state_e;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/vram_write_scheduler_m_if.sv
// CPU-side write bus and VRAM-side write port of the scheduler.
// master: the CPU/VRAM environment; slave: the scheduler.
interface vram_write_scheduler_m_if
  import vram_write_scheduler_m_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
);

  logic              cpu_wr_valid;
  logic [ADDR_W-1:0] cpu_wr_addr;
  logic [DATA_W-1:0] cpu_wr_data;
  logic              cpu_wr_ready;

  logic              vram_wr_en;
  logic [ADDR_W-1:0] vram_wr_addr;
  logic [DATA_W-1:0] vram_wr_data;

  modport master (
    output cpu_wr_valid,
    output cpu_wr_addr,
    output cpu_wr_data,
    input  cpu_wr_ready,
    input  vram_wr_en,
    input  vram_wr_addr,
    input  vram_wr_data
  );

  modport slave (
    input  cpu_wr_valid,
    input  cpu_wr_addr,
    input  cpu_wr_data,
    output cpu_wr_ready,
    output vram_wr_en,
    output vram_wr_addr,
    output vram_wr_data
  );

endinterface

// File: rtl/vram_write_scheduler_m_sync_fifo.sv
// Generic single-clock FIFO. Push into a full FIFO and pop from an empty
// FIFO are ignored. Read data is the current head (show-ahead).
module sync_fifo_m #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage array: data only, never reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vram_write_scheduler_m.sv
// VRAM write scheduler: buffers CPU writes in order and replays them to the
// VRAM port only during vertical blanking, yielding to GPU reads.
module vram_write_scheduler_m
  import vram_write_scheduler_m_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
  parameter int ADDR_W     = ADDR_W_DEFAULT
) (
  input  logic                          clk_12_5875,
  input  logic                          rst_B,
  vram_write_scheduler_m_if.slave       bus,
  input  logic                          vblank,
  input  logic                          gpu_rd_active,
  input  logic                          status_clear,
  output logic [cnt_w(FIFO_DEPTH)-1:0]  pending,
  output logic                          overflow,
  output logic                          late
);

  localparam int ENTRY_W = ADDR_W + DATA_W;

  sched_state_e               state_q;
  sched_state_e               state_d;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic                       push;
  logic                       pop;
  logic                       ovf_set;
  logic                       late_set;
  logic [ENTRY_W-1:0]         push_entry;
  logic [ENTRY_W-1:0]         pop_entry;
  logic [cnt_w(FIFO_DEPTH)-1:0] fifo_count;

  // Readiness comes from registered occupancy only, so a pop in the same
  // cycle never lets a full FIFO take a write.
  assign bus.cpu_wr_ready = !fifo_full;
  assign push             = bus.cpu_wr_valid && !fifo_full;
  assign ovf_set          = bus.cpu_wr_valid && fifo_full;
  assign push_entry       = {bus.cpu_wr_addr, bus.cpu_wr_data};
  assign pending          = fifo_count;

  sync_fifo_m #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_12_5875),
    .rst_n     (rst_B),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (pop_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Scheduler state register.
  always_ff @(posedge clk_12_5875 or negedge rst_B) begin
    if (!rst_B) begin
      state_q <= ST_WAIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, pop request and late detection. Popping stops in the cycle
  // vblank is seen low, so the queue is stable when judging lateness.
  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    late_set = 1'b0;
    case (state_q)
      ST_WAIT: begin
        if (vblank) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!vblank) begin
          state_d  = ST_WAIT;
          late_set = !fifo_empty;
        end else begin
          pop = !gpu_rd_active && !fifo_empty;
        end
      end
      default: state_d = ST_WAIT;
    endcase
  end

  // VRAM write port register; address/data hold between strobes.
  always_ff @(posedge clk_12_5875 or negedge rst_B) begin
    if (!rst_B) begin
      bus.vram_wr_en   <= 1'b0;
      bus.vram_wr_addr <= '0;
      bus.vram_wr_data <= '0;
    end else begin
      bus.vram_wr_en <= pop;
      if (pop) begin
        {bus.vram_wr_addr, bus.vram_wr_data} <= pop_entry;
      end
    end
  end

  // Sticky status flags; a set event in the same cycle beats status_clear.
  always_ff @(posedge clk_12_5875 or negedge rst_B) begin
    if (!rst_B) begin
      overflow <= 1'b0;
      late     <= 1'b0;
    end else begin
      overflow <= ovf_set  || (overflow && !status_clear);
      late     <= late_set || (late && !status_clear);
    end
  end

endmodule

// File: tb/tb_vram_write_scheduler_m.sv
// Bench for vram_write_scheduler_m: directed table, directed corner-case
// sequences and randomized traffic against a queue-based reference model.
module tb_vram_write_scheduler_m;

  localparam int DEPTH = 8;
  localparam int AW    = 12;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk_12_5875 = 1'b0;
  logic          rst_B;
  logic          vblank;
  logic          gpu_rd_active;
  logic          status_clear;
  logic [CW-1:0] pending;
  logic          overflow;
  logic          late;

  vram_write_scheduler_m_if #(.ADDR_W(AW)) bus ();

  vram_write_scheduler_m #(
    .FIFO_DEPTH (DEPTH),
    .ADDR_W     (AW)
  ) dut (
    .clk_12_5875   (clk_12_5875),
    .rst_B         (rst_B),
    .bus           (bus.slave),
    .vblank        (vblank),
    .gpu_rd_active (gpu_rd_active),
    .status_clear  (status_clear),
    .pending       (pending),
    .overflow      (overflow),
    .late          (late)
  );

  always #5 clk_12_5875 = ~clk_12_5875;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: an ordered queue of pending writes plus the observed
  // outputs. Draining is active in the cycle after vblank is seen high.
  typedef struct {
    logic [AW-1:0] a;
    logic [7:0]    d;
  } ent_t;

  ent_t          mq[$];
  bit            m_drain;
  bit            m_en;
  logic [AW-1:0] m_addr;
  logic [7:0]    m_data;
  bit            m_ovf;
  bit            m_late;

  logic [AW-1:0] em_a[$];
  logic [7:0]    em_d[$];

  typedef struct {
    bit            v;
    logic [AW-1:0] a;
    logic [7:0]    d;
    bit            vb;
    bit            gp;
    bit            clr;
    bit            e_rdy;
    bit            e_en;
    logic [AW-1:0] e_a;
    logic [7:0]    e_d;
    int            e_pend;
    bit            e_ovf;
    bit            e_late;
  } vec_t;

  vec_t tbl[17];

  function automatic vec_t mk(input bit v, input logic [AW-1:0] a, input logic [7:0] d,
                              input bit vb, input bit gp, input bit clr, input bit e_rdy,
                              input bit e_en, input logic [AW-1:0] e_a, input logic [7:0] e_d,
                              input int e_pend, input bit e_ovf, input bit e_late);
    vec_t r;
    r.v = v; r.a = a; r.d = d; r.vb = vb; r.gp = gp; r.clr = clr;
    r.e_rdy = e_rdy; r.e_en = e_en; r.e_a = e_a; r.e_d = e_d;
    r.e_pend = e_pend; r.e_ovf = e_ovf; r.e_late = e_late;
    return r;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drv(input bit v, input logic [AW-1:0] a, input logic [7:0] d,
                     input bit vb, input bit gp, input bit clr);
    bus.cpu_wr_valid = v;
    bus.cpu_wr_addr  = a;
    bus.cpu_wr_data  = d;
    vblank           = vb;
    gpu_rd_active    = gp;
    status_clear     = clr;
  endtask

  // Compare outputs of the current cycle against the model, away from the edge.
  task automatic sample();
    @(negedge clk_12_5875);
    if (bus.vram_wr_en) begin
      em_a.push_back(bus.vram_wr_addr);
      em_d.push_back(bus.vram_wr_data);
    end
    check("m_en",   32'(bus.vram_wr_en),   32'(m_en));
    check("m_addr", 32'(bus.vram_wr_addr), 32'(m_addr));
    check("m_data", 32'(bus.vram_wr_data), 32'(m_data));
    check("m_pend", 32'(pending),          32'(mq.size()));
    check("m_rdy",  32'(bus.cpu_wr_ready), 32'(mq.size() < DEPTH));
    check("m_ovf",  32'(overflow),         32'(m_ovf));
    check("m_late", 32'(late),             32'(m_late));
  endtask

  // Apply this cycle's inputs to the model, then cross the clock edge.
  task automatic advance();
    bit   full_now;
    bit   late_set;
    bit   ovf_set;
    ent_t it;
    full_now = (mq.size() == DEPTH);
    late_set = m_drain && !vblank && (mq.size() != 0);
    ovf_set  = bus.cpu_wr_valid && full_now;
    if (m_drain && vblank && !gpu_rd_active && mq.size() != 0) begin
      it     = mq.pop_front();
      m_en   = 1'b1;
      m_addr = it.a;
      m_data = it.d;
    end else begin
      m_en = 1'b0;
    end
    if (bus.cpu_wr_valid && !full_now) begin
      it.a = bus.cpu_wr_addr;
      it.d = bus.cpu_wr_data;
      mq.push_back(it);
    end
    m_ovf   = ovf_set  || (m_ovf  && !status_clear);
    m_late  = late_set || (m_late && !status_clear);
    m_drain = vblank;
    @(posedge clk_12_5875);
    #1;
  endtask

  task automatic cycle();
    sample();
    advance();
  endtask

  task automatic do_reset();
    rst_B = 1'b0;
    drv(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    #1;
    check("rst_en",   32'(bus.vram_wr_en),   32'd0);
    check("rst_addr", 32'(bus.vram_wr_addr), 32'd0);
    check("rst_data", 32'(bus.vram_wr_data), 32'd0);
    check("rst_pend", 32'(pending),          32'd0);
    check("rst_rdy",  32'(bus.cpu_wr_ready), 32'd1);
    check("rst_ovf",  32'(overflow),         32'd0);
    check("rst_late", 32'(late),             32'd0);
    mq.delete();
    m_drain = 1'b0; m_en = 1'b0; m_addr = '0; m_data = '0; m_ovf = 1'b0; m_late = 1'b0;
    repeat (2) @(posedge clk_12_5875);
    #1;
    rst_B = 1'b1;
    em_a.delete();
    em_d.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit vb_r;

    // Four writes in active video, then a vblank drain, then a lone write
    // into an empty FIFO while draining (2-cycle latency).
    tbl[0]  = mk(1, 12'h700, 8'h00, 0, 0, 0,  1, 0, 12'h000, 8'h00, 0, 0, 0);
    tbl[1]  = mk(1, 12'h701, 8'h01, 0, 0, 0,  1, 0, 12'h000, 8'h00, 1, 0, 0);
    tbl[2]  = mk(1, 12'h702, 8'h02, 0, 0, 0,  1, 0, 12'h000, 8'h00, 2, 0, 0);
    tbl[3]  = mk(1, 12'h703, 8'h03, 0, 0, 0,  1, 0, 12'h000, 8'h00, 3, 0, 0);
    tbl[4]  = mk(0, 12'h000, 8'h00, 0, 0, 0,  1, 0, 12'h000, 8'h00, 4, 0, 0);
    tbl[5]  = mk(0, 12'h000, 8'h00, 1, 0, 0,  1, 0, 12'h000, 8'h00, 4, 0, 0);
    tbl[6]  = mk(0, 12'h000, 8'h00, 1, 0, 0,  1, 0, 12'h000, 8'h00, 4, 0, 0);
    tbl[7]  = mk(0, 12'h000, 8'h00, 1, 0, 0,  1, 1, 12'h700, 8'h00, 3, 0, 0);
    tbl[8]  = mk(0, 12'h000, 8'h00, 1, 0, 0,  1, 1, 12'h701, 8'h01, 2, 0, 0);
    tbl[9]  = mk(0, 12'h000, 8'h00, 1, 0, 0,  1, 1, 12'h702, 8'h02, 1, 0, 0);
    tbl[10] = mk(0, 12'h000, 8'h00, 1, 0, 0,  1, 1, 12'h703, 8'h03, 0, 0, 0);
    tbl[11] = mk(0, 12'h000, 8'h00, 1, 0, 0,  1, 0, 12'h703, 8'h03, 0, 0, 0);
    tbl[12] = mk(1, 12'hF00, 8'h07, 1, 0, 0,  1, 0, 12'h703, 8'h03, 0, 0, 0);
    tbl[13] = mk(0, 12'h000, 8'h00, 1, 0, 0,  1, 0, 12'h703, 8'h03, 1, 0, 0);
    tbl[14] = mk(0, 12'h000, 8'h00, 1, 0, 0,  1, 1, 12'hF00, 8'h07, 0, 0, 0);
    tbl[15] = mk(0, 12'h000, 8'h00, 0, 0, 0,  1, 0, 12'hF00, 8'h07, 0, 0, 0);
    tbl[16] = mk(0, 12'h000, 8'h00, 0, 0, 0,  1, 0, 12'hF00, 8'h07, 0, 0, 0);

    rst_B = 1'b0;
    drv(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk_12_5875);
    #1;
    do_reset();

    // Directed table; row 0 also exercises an enqueue right after reset release.
    for (int i = 0; i < 17; i++) begin
      drv(tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].vb, tbl[i].gp, tbl[i].clr);
      sample();
      check($sformatf("tbl%0d_rdy", i),  32'(bus.cpu_wr_ready), 32'(tbl[i].e_rdy));
      check($sformatf("tbl%0d_en", i),   32'(bus.vram_wr_en),   32'(tbl[i].e_en));
      check($sformatf("tbl%0d_addr", i), 32'(bus.vram_wr_addr), 32'(tbl[i].e_a));
      check($sformatf("tbl%0d_data", i), 32'(bus.vram_wr_data), 32'(tbl[i].e_d));
      check($sformatf("tbl%0d_pend", i), 32'(pending),          32'(tbl[i].e_pend));
      check($sformatf("tbl%0d_ovf", i),  32'(overflow),         32'(tbl[i].e_ovf));
      check($sformatf("tbl%0d_late", i), 32'(late),             32'(tbl[i].e_late));
      advance();
    end

    // Overflow: 16 writes into an 8-deep FIFO during active video.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drv(1'b1, AW'(12'h700 + i), 8'(i), 1'b0, 1'b0, 1'b0);
      sample();
      if (i == 7) check("ovf_rdy7", 32'(bus.cpu_wr_ready), 32'd1);
      if (i == 8) check("ovf_rdy8", 32'(bus.cpu_wr_ready), 32'd0);
      if (i == 8) check("ovf_flag_pre", 32'(overflow), 32'd0);
      if (i == 9) check("ovf_flag", 32'(overflow), 32'd1);
      advance();
    end
    drv(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    cycle();
    drv(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    sample();
    check("ovf_cleared", 32'(overflow), 32'd0);
    advance();
    drv(1'b1, 12'h7AA, 8'hAA, 1'b0, 1'b0, 1'b1);
    cycle();
    drv(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    sample();
    check("ovf_set_wins", 32'(overflow), 32'd1);
    advance();
    em_a.delete();
    em_d.delete();
    drv(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    repeat (14) cycle();
    check("ovf_drain_cnt", 32'(em_a.size()), 32'd8);
    for (int k = 0; k < 8 && k < em_a.size(); k++) begin
      check($sformatf("ovf_drain_a%0d", k), 32'(em_a[k]), 32'h700 + 32'(k));
    end

    // GPU read ownership pauses the drain.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drv(1'b1, AW'(12'hA00 + i), 8'(8'h50 + i), 1'b0, 1'b0, 1'b0);
      cycle();
    end
    drv(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    cycle();
    em_a.delete();
    em_d.delete();
    drv(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
    repeat (10) cycle();
    check("gpu_hold_cnt", 32'(em_a.size()), 32'd0);
    check("gpu_hold_pend", 32'(pending), 32'd3);
    drv(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    sample();
    check("gpu_fall_en", 32'(bus.vram_wr_en), 32'd0);
    advance();
    sample();
    check("gpu_resume_en", 32'(bus.vram_wr_en), 32'd1);
    check("gpu_resume_addr", 32'(bus.vram_wr_addr), 32'hA00);
    advance();
    repeat (3) cycle();
    check("gpu_cnt", 32'(em_a.size()), 32'd3);
    if (em_a.size() == 3) begin
      check("gpu_a1", 32'(em_a[1]), 32'hA01);
      check("gpu_a2", 32'(em_a[2]), 32'hA02);
      check("gpu_d2", 32'(em_d[2]), 32'h52);
    end

    // vblank ends with writes still queued: late, remainder kept in order.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drv(1'b1, AW'(12'hF00 + i), 8'(i), 1'b0, 1'b0, 1'b0);
      cycle();
    end
    em_a.delete();
    em_d.delete();
    drv(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    repeat (4) cycle();
    drv(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    repeat (3) cycle();
    check("late_emit_cnt", 32'(em_a.size()), 32'd3);
    check("late_flag", 32'(late), 32'd1);
    check("late_pend", 32'(pending), 32'd5);
    drv(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    repeat (12) cycle();
    check("late_total", 32'(em_a.size()), 32'd8);
    for (int k = 0; k < 8 && k < em_a.size(); k++) begin
      check($sformatf("late_a%0d", k), 32'(em_a[k]), 32'hF00 + 32'(k));
      check($sformatf("late_d%0d", k), 32'(em_d[k]), 32'(k));
    end
    check("late_sticky", 32'(late), 32'd1);
    drv(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    cycle();
    drv(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    cycle();
    check("late_cleared", 32'(late), 32'd0);

    // Reset asserted mid-drain discards the queue.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drv(1'b1, AW'(12'h500 + i), 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
      cycle();
    end
    drv(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    repeat (4) cycle();
    check("rst_pre_pend", 32'(pending), 32'd5);
    do_reset();
    drv(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    repeat (12) cycle();
    check("rst_no_emit", 32'(em_a.size()), 32'd0);

    // Randomized traffic against the model.
    do_reset();
    vb_r = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 15) == 0) vb_r = !vb_r;
      drv(1'($urandom_range(0, 1)), AW'($urandom), 8'($urandom), vb_r,
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 19) == 0));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
